// File: rtl/multdiv_iter.sv
// Iterative signed 32-bit multiply (radix-2 shift-add) / divide (restoring), one bit per cycle.
// Optional macro MULTDIV_DIV0_FAST_EN: divide-by-zero completes right after operand preparation.
module multdiv_iter (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        prep_q, prep_d;
    logic        div_q, div_d;
    logic        neg_q, neg_d;
    logic [63:0] acc_q, acc_d;
    logic [63:0] opa_q, opa_d;
    logic [32:0] opb_q, opb_d;
    logic [31:0] res_q, res_d;
    logic        exc_q, exc_d;

    logic [31:0] mag_a, mag_b;
    logic [32:0] rem_sh;
    logic [33:0] diff;
    logic [63:0] prod_s;
    logic [31:0] quo, quo_s;

    assign data_result    = res_q;
    assign data_exception = exc_q;
    assign data_resultRDY = (state_q == ST_DONE);
    assign busy           = (state_q == ST_RUN);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prep_d  = prep_q;
        div_d   = div_q;
        neg_d   = neg_q;
        acc_d   = acc_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        exc_d   = exc_q;
        prod_s  = '0;
        quo     = '0;
        quo_s   = '0;

        // 32-bit unsigned magnitude represents 2^31 exactly for 0x80000000
        mag_a  = opa_q[31] ? (~opa_q[31:0] + 32'd1) : opa_q[31:0];
        mag_b  = opb_q[31] ? (~opb_q[31:0] + 32'd1) : opb_q[31:0];
        rem_sh = {acc_q[31:0], opa_q[31]};
        diff   = {1'b0, rem_sh} - {2'b00, opb_q[31:0]};

        case (state_q)
            ST_RUN: begin
                if (prep_q) begin
                    // First RUN cycle converts latched raw operands to magnitudes
                    prep_d = 1'b0;
                    neg_d  = opa_q[31] ^ opb_q[31];
                    opa_d  = {32'd0, mag_a};
                    opb_d  = {1'b0, mag_b};
                    acc_d  = '0;
`ifdef MULTDIV_DIV0_FAST_EN
                    if (div_q && (opb_q[31:0] == 32'd0)) begin
                        state_d = ST_DONE;
                        res_d   = '0;
                        exc_d   = 1'b1;
                    end
`else
`endif
                end else begin
                    cnt_d = cnt_q + 5'd1;
                    if (div_q) begin
                        // Dividend shifts out the top while quotient bits shift in at the bottom
                        if (!diff[33]) begin
                            acc_d = {31'd0, diff[32:0]};
                            opa_d = {32'd0, opa_q[30:0], 1'b1};
                        end else begin
                            acc_d = {31'd0, rem_sh};
                            opa_d = {32'd0, opa_q[30:0], 1'b0};
                        end
                    end else begin
                        if (opb_q[0]) begin
                            acc_d = acc_q + opa_q;
                        end
                        opa_d = opa_q << 1;
                        opb_d = opb_q >> 1;
                    end

                    if (cnt_q == 5'd31) begin
                        state_d = ST_DONE;
                        if (div_q) begin
                            quo   = opa_d[31:0];
                            quo_s = neg_q ? (~quo + 32'd1) : quo;
                            if (opb_q[31:0] == 32'd0) begin
                                res_d = '0;
                                exc_d = 1'b1;
                            end else begin
                                res_d = quo_s;
                                exc_d = quo[31] & ~neg_q;
                            end
                        end else begin
                            prod_s = neg_q ? (~acc_d + 64'd1) : acc_d;
                            res_d  = prod_s[31:0];
                            exc_d  = !((&prod_s[63:31]) || (~|prod_s[63:31]));
                        end
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // A start overrides whatever is in flight
        if (ctrl_MULT || ctrl_DIV) begin
            state_d = ST_RUN;
            prep_d  = 1'b1;
            cnt_d   = '0;
            div_d   = ctrl_DIV & ~ctrl_MULT;
            opa_d   = {32'd0, data_operandA};
            opb_d   = {1'b0, data_operandB};
            acc_d   = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            prep_q  <= 1'b0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            acc_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prep_q  <= prep_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            acc_q   <= acc_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            exc_q   <= exc_d;
        end
    end

endmodule
